// File: rtl/sdds_pkg.sv
// Shared types and dual-rail code helpers for the SDDS
// dual-rail to single-rail sink stage.
package sdds_pkg;

   typedef enum logic {
      IDLE,
      WAIT_NULL
   } state_e;

   // Per-bit codes as {t, f}
   localparam logic [1:0] DR_NULL    = 2'b00;
   localparam logic [1:0] DR_DATA0   = 2'b01;
   localparam logic [1:0] DR_DATA1   = 2'b10;
   localparam logic [1:0] DR_ILLEGAL = 2'b11;

   localparam int DR_MAX_W = 64;

   typedef struct packed {
      logic complete;
      logic is_null;
      logic illegal;
   } dr_stat_t;

   // Bits outside mask are ignored so narrower words can be zero-extended.
   function automatic dr_stat_t dr_complete(
      input logic [DR_MAX_W-1:0] t,
      input logic [DR_MAX_W-1:0] f,
      input logic [DR_MAX_W-1:0] mask
   );
      dr_stat_t s;
      s.complete = 1'b1;
      s.is_null  = 1'b1;
      s.illegal  = 1'b0;
      for (int i = 0; i < DR_MAX_W; i++) begin
         if (mask[i]) begin
            case ({t[i], f[i]})
               DR_NULL: s.complete = 1'b0;
               DR_DATA0,
               DR_DATA1: s.is_null = 1'b0;
               DR_ILLEGAL: begin
                  s.complete = 1'b0;
                  s.is_null  = 1'b0;
                  s.illegal  = 1'b1;
               end
               default: s.complete = 1'b0;
            endcase
         end
      end
      return s;
   endfunction

endpackage

// File: rtl/sdds_sync_fifo.sv
// Small synchronous FIFO; push while full is allowed when a pop
// happens on the same edge.
module sdds_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                       ck,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q;
   logic [AW-1:0]    rptr_q;
   logic [AW-1:0]    rprev;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign count   = count_q;
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rprev   = rptr_q - AW'(1);

   // When empty, keep showing the entry most recently popped.
   assign dout = empty ? mem_q[rprev] : mem_q[rptr_q];

   always_ff @(posedge ck or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wptr_q] <= din;
            wptr_q        <= wptr_q + AW'(1);
         end
         if (do_pop) rptr_q <= rptr_q + AW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/sdds_dr2sr.sv
// Dual-rail to single-rail sink: completion detection, 4-phase
// ack handshake, output FIFO and accepted-token counter.
module sdds_dr2sr
   import sdds_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             ck,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_t,
   input  logic [WIDTH-1:0] in_f,
   output logic             in_ack,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             err,
   output logic [CNT_W-1:0] tok_cnt
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [DR_MAX_W-1:0] MASK = DR_MAX_W'({WIDTH{1'b1}});

   state_e           state_q, state_d;
   logic             ack_q, ack_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             push;
   logic             pop;
   logic             space;
   logic             empty;
   logic             full_unused;
   logic [CW-1:0]    count;
   dr_stat_t         st;

   assign st = dr_complete(DR_MAX_W'(in_t), DR_MAX_W'(in_f), MASK);

   assign out_valid = ~empty;
   assign pop       = out_valid & out_ready;
   assign space     = (count < CW'(DEPTH)) | pop;

   assign in_ack  = ack_q;
   assign err     = err_q;
   assign tok_cnt = cnt_q;

   sdds_sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .ck    (ck),
      .reset (reset),
      .push  (push),
      .din   (in_t),
      .pop   (pop),
      .dout  (out_data),
      .empty (empty),
      .full  (full_unused),
      .count (count)
   );

   always_ff @(posedge ck or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ack_d   = ack_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      push    = 1'b0;
      case (state_q)
         IDLE: begin
            // Illegal words are acked and dropped so upstream can recover.
            if (st.illegal) begin
               err_d   = 1'b1;
               ack_d   = 1'b1;
               state_d = WAIT_NULL;
            end else if (st.complete && space) begin
               push    = 1'b1;
               cnt_d   = cnt_q + 1'b1;
               ack_d   = 1'b1;
               state_d = WAIT_NULL;
            end
         end
         WAIT_NULL: begin
            if (st.is_null) begin
               ack_d   = 1'b0;
               state_d = IDLE;
            end else if (st.illegal) begin
               err_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_sdds_dr2sr.sv
// Self-checking bench for sdds_dr2sr against a queue-based model
// of the handshake, FIFO and counter rules.
module tb_sdds_dr2sr;

   localparam int W  = 8;
   localparam int D  = 2;
   localparam int CW = 4;

   logic          ck = 1'b0;
   logic          reset = 1'b1;
   logic [W-1:0]  in_t = '0;
   logic [W-1:0]  in_f = '0;
   logic          out_ready = 1'b0;
   logic          in_ack;
   logic [W-1:0]  out_data;
   logic          out_valid;
   logic          err;
   logic [CW-1:0] tok_cnt;

   sdds_dr2sr #(
      .WIDTH (W),
      .DEPTH (D),
      .CNT_W (CW)
   ) dut (
      .ck        (ck),
      .reset     (reset),
      .in_t      (in_t),
      .in_f      (in_f),
      .in_ack    (in_ack),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .err       (err),
      .tok_cnt   (tok_cnt)
   );

   always #5 ck = ~ck;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] q[$];
   int           m_cnt;
   bit           m_err;
   bit           m_ack;

   task automatic model_reset();
      q.delete();
      m_cnt = 0;
      m_err = 1'b0;
      m_ack = 1'b0;
   endtask

   task automatic drive(input logic [W-1:0] t, input logic [W-1:0] f,
                        input logic rdy);
      in_t      = t;
      in_f      = f;
      out_ready = rdy;
   endtask

   // Advance one ck edge, updating the model from the inputs seen at it.
   task automatic step();
      bit cmp, nul, ill, popm, pushm, sp;
      bit n_ack, n_err;
      logic [W-1:0] v;
      cmp   = ((in_t ^ in_f) == '1);
      nul   = ((in_t | in_f) == '0);
      ill   = ((in_t & in_f) != '0);
      popm  = (q.size() != 0) && out_ready;
      sp    = (q.size() < D) || popm;
      pushm = 1'b0;
      n_ack = m_ack;
      n_err = m_err;
      v     = in_t;
      if (!m_ack) begin
         if (ill) begin
            n_err = 1'b1;
            n_ack = 1'b1;
         end else if (cmp && sp) begin
            pushm = 1'b1;
            n_ack = 1'b1;
         end
      end else if (nul) begin
         n_ack = 1'b0;
      end else if (ill) begin
         n_err = 1'b1;
      end
      @(posedge ck);
      #1;
      if (popm) void'(q.pop_front());
      if (pushm) begin
         q.push_back(v);
         m_cnt = (m_cnt + 1) % (1 << CW);
      end
      m_ack = n_ack;
      m_err = n_err;
   endtask

   function automatic logic [14:0] obs();
      return {in_ack, out_valid, (out_valid ? out_data : 8'h00), tok_cnt, err};
   endfunction

   function automatic logic [14:0] exp_vec();
      bit v;
      logic [W-1:0] d;
      v = (q.size() != 0);
      d = v ? q[0] : 8'h00;
      return {m_ack, v, d, 4'(m_cnt), m_err};
   endfunction

   task automatic test_reset();
      #12;
      checks++;
      if (obs() !== 15'h0 || out_data !== 8'h00) begin
         errors++;
         $display("FAIL reset got %h data %h want 0000 data 00", obs(), out_data);
      end
      @(negedge ck);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_basic();
      drive(8'hA5, 8'h5A, 1'b0);
      step();
      checks++;
      if (obs() !== exp_vec() || out_data !== 8'hA5 || tok_cnt !== 4'd1) begin
         errors++;
         $display("FAIL basic_tok got %h want %h", obs(), exp_vec());
      end
      drive(8'h00, 8'h00, 1'b0);
      step();
      checks++;
      if (obs() !== exp_vec() || in_ack !== 1'b0) begin
         errors++;
         $display("FAIL basic_null got %h want %h", obs(), exp_vec());
      end
      drive(8'h00, 8'h00, 1'b1);
      step();
      checks++;
      if (obs() !== exp_vec()) begin
         errors++;
         $display("FAIL basic_pop got %h want %h", obs(), exp_vec());
      end
   endtask

   task automatic test_partial();
      for (int i = 0; i < 3; i++) begin
         drive(8'h06, 8'h09, 1'b0);
         step();
         checks++;
         if (obs() !== exp_vec() || in_ack !== 1'b0) begin
            errors++;
            $display("FAIL partial_wait%0d got %h want %h", i, obs(), exp_vec());
         end
      end
      drive(8'h96, 8'h69, 1'b0);
      step();
      checks++;
      if (obs() !== exp_vec() || out_data !== 8'h96) begin
         errors++;
         $display("FAIL partial_done got %h want %h", obs(), exp_vec());
      end
      drive(8'h00, 8'h00, 1'b1);
      step();
      step();
      checks++;
      if (obs() !== exp_vec()) begin
         errors++;
         $display("FAIL partial_drain got %h want %h", obs(), exp_vec());
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] tok [4];
      tok = '{8'h01, 8'h02, 8'h03, 8'h00};
      for (int i = 0; i < 2; i++) begin
         drive(tok[i], ~tok[i], 1'b0);
         step();
         drive(8'h00, 8'h00, 1'b0);
         step();
      end
      for (int i = 0; i < 2; i++) begin
         drive(8'h03, 8'hFC, 1'b0);
         step();
         checks++;
         if (obs() !== exp_vec() || in_ack !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d got %h want %h", i, obs(), exp_vec());
         end
      end
      drive(8'h03, 8'hFC, 1'b1);
      step();
      checks++;
      if (obs() !== exp_vec() || in_ack !== 1'b1 || out_data !== 8'h02) begin
         errors++;
         $display("FAIL bp_swap got %h want %h", obs(), exp_vec());
      end
      drive(8'h00, 8'h00, 1'b0);
      step();
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (obs() !== exp_vec() || out_data !== tok[i+1]) begin
            errors++;
            $display("FAIL bp_order%0d got %h want %h", i, obs(), exp_vec());
         end
         drive(8'h00, 8'h00, 1'b1);
         step();
      end
      checks++;
      if (obs() !== exp_vec() || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_empty got %h want %h", obs(), exp_vec());
      end
   endtask

   task automatic test_illegal();
      drive(8'h35, 8'hCE, 1'b0);
      step();
      checks++;
      if (obs() !== exp_vec() || err !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL illegal_idle got %h want %h", obs(), exp_vec());
      end
      drive(8'h00, 8'h00, 1'b0);
      step();
      drive(8'h7E, 8'h81, 1'b0);
      step();
      checks++;
      if (obs() !== exp_vec() || out_data !== 8'h7E || err !== 1'b1) begin
         errors++;
         $display("FAIL illegal_after got %h want %h", obs(), exp_vec());
      end
      drive(8'h00, 8'h00, 1'b1);
      step();
   endtask

   task automatic test_wrap();
      logic [W-1:0] tok, mask;
      bit need;
      drive(8'h00, 8'h00, 1'b1);
      reset = 1'b1;
      #2;
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < 17; i++) begin
         tok = W'($urandom);
         drive(tok, ~tok, 1'b1);
         step();
         checks++;
         if (obs() !== exp_vec()) begin
            errors++;
            $display("FAIL wrap_tok%0d got %h want %h", i, obs(), exp_vec());
         end
         drive(8'h00, 8'h00, 1'b1);
         step();
      end
      checks++;
      if (tok_cnt !== 4'd1) begin
         errors++;
         $display("FAIL wrap_cnt got %0d want 1", tok_cnt);
      end
      need = 1'b1;
      tok  = '0;
      for (int c = 0; c < 400; c++) begin
         if (!m_ack) begin
            if (need) tok = W'($urandom);
            need = 1'b0;
            mask = ($urandom_range(0, 3) == 0) ? W'($urandom) : '1;
            in_t = tok & mask;
            in_f = ~tok & mask;
            if ($urandom_range(0, 59) == 0) begin
               in_t[0] = 1'b1;
               in_f[0] = 1'b1;
            end
         end else begin
            need = 1'b1;
            mask = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            in_t = tok & mask;
            in_f = ~tok & mask;
         end
         out_ready = ($urandom_range(0, 2) != 0);
         step();
         checks++;
         if (obs() !== exp_vec()) begin
            errors++;
            $display("FAIL rand_c%0d got %h want %h", c, obs(), exp_vec());
         end
      end
   endtask

   task automatic test_reset_mid();
      drive(8'h00, 8'h00, 1'b0);
      while (m_ack) step();
      drive(8'h55, 8'hAA, 1'b0);
      step();
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (obs() !== 15'h0) begin
         errors++;
         $display("FAIL reset_mid got %h want 0000", obs());
      end
      drive(8'h3C, 8'hC3, 1'b0);
      @(negedge ck);
      reset = 1'b0;
      model_reset();
      step();
      checks++;
      if (obs() !== exp_vec() || out_data !== 8'h3C || tok_cnt !== 4'd1) begin
         errors++;
         $display("FAIL reset_reacc got %h want %h", obs(), exp_vec());
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_partial();
      test_backpressure();
      test_illegal();
      test_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
